// File: rtl/std_mult_seq.sv
// Iterative radix-2 shift-and-add unsigned multiplier with a go/done handshake.
// Consumes one multiplier bit per cycle and returns the low width bits of left*right.
module std_mult_seq #(
   parameter int unsigned width = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             go_i,
   input  logic [width-1:0] left_i,
   input  logic [width-1:0] right_i,
   output logic [width-1:0] out_o,
   output logic             done_o
);

   localparam int unsigned CW = $clog2(width + 1);
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [width-1:0] mcand_q, mcand_d;
   logic [width-1:0] mplier_q, mplier_d;
   logic [width-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [width-1:0] out_q, out_d;
   logic             done_q, done_d;
   logic [width-1:0] sum;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      done_d   = done_q;
      // Accumulator value including this iteration's partial product.
      sum      = mplier_q[0] ? acc_q + mcand_q : acc_q;

      unique case (state_q)
         IDLE: begin
            out_d  = '0;
            done_d = 1'b0;
            if (go_i) begin
               if (left_i == '0 || right_i == '0) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  mcand_d  = left_i;
                  mplier_d = right_i;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            if (!go_i) begin
               out_d   = '0;
               done_d  = 1'b0;
               state_d = IDLE;
            end else begin
               acc_d    = sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  out_d   = sum;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!go_i) begin
               out_d   = '0;
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            out_d   = '0;
            done_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign out_o  = out_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_std_mult_seq.sv
// Directed and randomized checks of std_mult_seq at width 8 and width 32.
module tb_std_mult_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        go8, go32;
   logic [7:0]  left8, right8, out8;
   logic [31:0] left32, right32, out32;
   logic        done8, done32;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   std_mult_seq #(.width(8)) dut8 (
      .clk_i(clk), .reset_i(reset), .go_i(go8),
      .left_i(left8), .right_i(right8), .out_o(out8), .done_o(done8)
   );

   std_mult_seq #(.width(32)) dut32 (
      .clk_i(clk), .reset_i(reset), .go_i(go32),
      .left_i(left32), .right_i(right32), .out_o(out32), .done_o(done32)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise go (if not already) and count edges until done; caller is at a negedge.
   task automatic run8(input string tag, input logic [7:0] l, input logic [7:0] r,
                       input int exp_lat, input logic [7:0] exp_out);
      int cyc = 0;
      left8 = l; right8 = r; go8 = 1'b1;
      do begin
         @(posedge clk); @(negedge clk); cyc++;
      end while (!done8 && cyc < 60);
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_out"}, {24'd0, out8}, {24'd0, exp_out});
      $display("op %s: %0d * %0d -> %0d after %0d cycles", tag, l, r, out8, cyc);
   endtask

   task automatic drop8(input string tag);
      go8 = 1'b0;
      @(posedge clk); @(negedge clk);
      check({tag, "_drop_done"}, {31'd0, done8}, 32'd0);
      check({tag, "_drop_out"}, {24'd0, out8}, 32'd0);
   endtask

   task automatic run32(input string tag, input logic [31:0] l, input logic [31:0] r,
                        input int exp_lat, input logic [31:0] exp_out);
      int cyc = 0;
      left32 = l; right32 = r; go32 = 1'b1;
      do begin
         @(posedge clk); @(negedge clk); cyc++;
      end while (!done32 && cyc < 80);
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_out"}, out32, exp_out);
      $display("op %s: %0h * %0h -> %0h after %0d cycles", tag, l, r, out32, cyc);
      go32 = 1'b0;
      @(posedge clk); @(negedge clk);
      check({tag, "_drop_done"}, {31'd0, done32}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      go8 = 1'b0; go32 = 1'b0;
      left8 = 8'd0; right8 = 8'd0; left32 = 32'd0; right32 = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_out8", {24'd0, out8}, 32'd0);
      check("rst_done8", {31'd0, done8}, 32'd0);
      check("rst_out32", out32, 32'd0);
      check("rst_done32", {31'd0, done32}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic product, hold while go stays high, clear on go low.
      run8("13x11", 8'd13, 8'd11, 9, 8'd143);
      @(posedge clk); @(negedge clk);
      check("13x11_hold_out", {24'd0, out8}, 32'd143);
      check("13x11_hold_done", {31'd0, done8}, 32'd1);
      drop8("13x11");

      run8("200x3", 8'd200, 8'd3, 9, 8'd88);
      drop8("200x3");
      run8("255x255", 8'd255, 8'd255, 9, 8'd1);
      drop8("255x255");
      run8("0x77", 8'd0, 8'd77, 1, 8'd0);
      drop8("0x77");
      run8("1x1", 8'd1, 8'd1, 9, 8'd1);
      drop8("1x1");

      run32("w32_0x12345", 32'd0, 32'h12345, 1, 32'd0);
      run32("w32_ffffffffx2", 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE);
      run32("w32_12345x0", 32'h12345, 32'd0, 1, 32'd0);

      // Abort after 4 edges, then a fresh operation with no leakage.
      left8 = 8'd13; right8 = 8'd11; go8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         check("abort_run_done", {31'd0, done8}, 32'd0);
      end
      drop8("abort");
      run8("7x9", 8'd7, 8'd9, 9, 8'd63);

      // Held go through DONE with changing operands: result must not move.
      left8 = 8'd2; right8 = 8'd2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done_hold_out", {24'd0, out8}, 32'd63);
      check("done_hold_done", {31'd0, done8}, 32'd1);
      drop8("7x9");

      run8("13x11b", 8'd13, 8'd11, 9, 8'd143);
      left8 = 8'd2; right8 = 8'd2;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("done_ignore_out", {24'd0, out8}, 32'd143);

      // Async reset in DONE clears outputs before any edge.
      #2 reset = 1'b1;
      #1;
      check("rst_in_done_out", {24'd0, out8}, 32'd0);
      check("rst_in_done_done", {31'd0, done8}, 32'd0);
      drop8("rst_in_done");
      reset = 1'b0;

      // Async reset mid-RUN with go held high: reset wins, restart after release.
      left8 = 8'd13; right8 = 8'd11; go8 = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_out", {24'd0, out8}, 32'd0);
      check("rst_mid_done", {31'd0, done8}, 32'd0);
      left8 = 8'd6; right8 = 8'd7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_go_held_done", {31'd0, done8}, 32'd0);
      reset = 1'b0;
      run8("6x7", 8'd6, 8'd7, 9, 8'd42);
      drop8("6x7");

      // Randomized operations against a behavioral model.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0]  l, r;
         logic [15:0] full;
         l = 8'($urandom_range(0, 255));
         r = 8'($urandom_range(0, 255));
         if (i % 50 == 0) l = 8'd0;
         full = 16'(l) * 16'(r);
         run8("rand", l, r, (l == 8'd0 || r == 8'd0) ? 1 : 9, full[7:0]);
         drop8("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
